ctl_ammo: RTL and testbench
===========================

Name: ctl_ammo

Overview:
- Ammunition controller for the game; replaces the constant ammo digits currently tied to disp_hex_mux hex0/hex1.
- Consumes shot_fired/hit from ctl_trigger and round/reload requests from game control.
- Produces two BCD digits for disp_hex_mux plus status flags: shot gating, empty and reload indication.
- Enforces a timed reload sequence.

Parameters:
- AMMO_MAX, 34, magazine size loaded at reset and after every reload; legal range 1..99.
- RELOAD_CYCLES, 65_000_000, clk cycles spent in RELOAD (1 s at 65 MHz); legal range >= 1.

Ports:
- clk  input  1  main clock, 65 MHz.
- rst  input  1  asynchronous, active-high reset.
- shot_fired  input  1  shot strobe from ctl_trigger; level or pulse, rising-edge detected internally.
- hit  input  1  hit strobe from ctl_trigger; rising-edge detected internally.
- new_round  input  1  single-cycle pulse; start of new round, forces reload.
- reload_req  input  1  player reload request (button/switch); rising-edge detected.
- hex0  output  4  ammo units digit, BCD 0..9.
- hex1  output  4  ammo tens digit, BCD 0..9.
- shot_allowed  output  1  high only in READY.
- ammo_empty  output  1  high only in EMPTY.
- reload_busy  output  1  high only in RELOAD.
- dry_fire  output  1  one-cycle pulse when a shot edge arrives outside READY.

Behaviour:
- Reset, asynchronous, while rst=1:
  - state=READY, ammo=AMMO_MAX, so hex1/hex0 show the BCD of AMMO_MAX (34 gives 3/4).
  - shot_allowed=1, ammo_empty=0, reload_busy=0, dry_fire=0.
  - Edge-detect registers and reload counter cleared to 0.
- Edge detection: event = in & ~in_q, where in_q is registered every clk. A held input produces exactly one event.
- Ammo is held directly as two BCD digits. Decrement: units 0 -> 9 with tens-1; otherwise units-1. No binary-to-BCD conversion.
- All outputs are registered. Any change from an event appears 1 clk after the cycle in which the edge was sampled.
- States and transitions:
  - READY:
    - Shot event: ammo-1.
    - If ammo was 01 when the shot occurred, go to EMPTY; ammo shows 00.
    - reload_req event or new_round: go to RELOAD, counter=0.
  - EMPTY:
    - Shot event: dry_fire pulse, ammo unchanged.
    - reload_req event or new_round: go to RELOAD.
  - RELOAD:
    - Counter increments every clk. Shot events give dry_fire. reload_req and new_round are ignored; no restart.
    - When counter = RELOAD_CYCLES-1: ammo=AMMO_MAX, go to READY, counter=0.
- Priority within one cycle: new_round/reload_req > shot.
  - A shot coinciding with a reload trigger in READY is not counted and produces no dry_fire.
  - State becomes RELOAD.
- Ammo never underflows below 00 and never exceeds AMMO_MAX.
- Reset asserted mid-RELOAD aborts the reload immediately and restores the reset values.
- hit has no effect unless CTL_AMMO_REFUND_EN is defined.

Optional Feature:
- Macro: CTL_AMMO_REFUND_EN.
- Defined:
  - A hit event in READY adds 1 ammo, saturating at AMMO_MAX. BCD increment: units 9 -> 0 with tens+1.
  - Hit and shot events in the same cycle give a net 0 change.
  - Hit events in EMPTY or RELOAD are ignored. EMPTY is left only via reload.
- Undefined: hit input unused; no refund logic synthesised.

Test Plan:
- Reset with AMMO_MAX=34, RELOAD_CYCLES=8 -> hex1=3, hex0=4, shot_allowed=1, other flags 0.
- 5 shot_fired pulses from 34 -> hex 2/9; shot_fired held high 20 clks -> exactly one decrement.
- AMMO_MAX=3, 4 shots -> ammo 00, ammo_empty=1, 4th shot gives a one-cycle dry_fire.
- From EMPTY, reload_req pulse:
  - reload_busy=1 for exactly 8 clks; shots during it give dry_fire.
  - Then ammo=AMMO_MAX and shot_allowed=1.
- new_round and shot_fired edge in the same cycle at ammo 10 -> state RELOAD, ammo stays 10, no dry_fire; assert rst mid-RELOAD -> immediate 34/READY.
- With CTL_AMMO_REFUND_EN, at 33:
  - hit -> 34.
  - hit at 34 -> stays 34.
  - Simultaneous hit+shot at 20 -> stays 20.

Source files
------------

// File: rtl/ctl_ammo.sv
// ctl_ammo: ammunition controller for the game.
// Keeps the magazine count as two BCD digits for disp_hex_mux (hex1 = tens,
// hex0 = units), gates shots, flags an empty magazine and runs a timed reload.
// Optional build macro: CTL_AMMO_REFUND_EN -- when defined, a hit in READY
// refunds one round (saturating at AMMO_MAX); when undefined, hit is ignored.
module ctl_ammo #(
  parameter int AMMO_MAX      = 34,
  parameter int RELOAD_CYCLES = 65_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       shot_fired,
  input  logic       hit,
  input  logic       new_round,
  input  logic       reload_req,
  output logic [3:0] hex0,
  output logic [3:0] hex1,
  output logic       shot_allowed,
  output logic       ammo_empty,
  output logic       reload_busy,
  output logic       dry_fire
);

  localparam int CNT_W = (RELOAD_CYCLES > 1) ? $clog2(RELOAD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RELOAD_CYCLES - 1);
  localparam logic [7:0] AMMO_FULL = {4'(AMMO_MAX / 10), 4'(AMMO_MAX % 10)};

  typedef enum logic [1:0] {
    ST_READY,
    ST_EMPTY,
    ST_RELOAD
  } state_t;

  state_t           state, state_nx;
  logic [7:0]       ammo, ammo_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             dry_nx;

  logic shot_fired_p0, reload_req_p0;
  logic shot_ev, reload_ev, reload_trig;

  // BCD decrement, saturating at 00.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v == 8'h00)           return 8'h00;
    else if (v[3:0] == 4'd0)  return {v[7:4] - 4'd1, 4'd9};
    else                      return {v[7:4], v[3:0] - 4'd1};
  endfunction

  // BCD increment, saturating at the full magazine.
  function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
    if (v >= AMMO_FULL)       return AMMO_FULL;
    else if (v[3:0] == 4'd9)  return {v[7:4] + 4'd1, 4'd0};
    else                      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Stage p0: previous-cycle copies of the strobes for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shot_fired_p0 <= 1'b0;
      reload_req_p0 <= 1'b0;
    end else begin
      shot_fired_p0 <= shot_fired;
      reload_req_p0 <= reload_req;
    end
  end

  assign shot_ev     = shot_fired & ~shot_fired_p0;
  assign reload_ev   = reload_req & ~reload_req_p0;
  assign reload_trig = new_round | reload_ev;

`ifdef CTL_AMMO_REFUND_EN
  logic hit_p0;
  logic hit_ev;

  // Stage p0: previous-cycle copy of hit for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hit_p0 <= 1'b0;
    else     hit_p0 <= hit;
  end

  assign hit_ev = hit & ~hit_p0;
`else
  logic unused_hit;
  assign unused_hit = hit;
`endif

  // Next-state and datapath decisions; reload triggers outrank shots.
  always_comb begin
    state_nx = state;
    ammo_nx  = ammo;
    cnt_nx   = cnt;
    dry_nx   = 1'b0;
    case (state)
      ST_READY: begin
        if (reload_trig) begin
          state_nx = ST_RELOAD;
          cnt_nx   = '0;
        end else begin
`ifdef CTL_AMMO_REFUND_EN
          // A hit and a shot in the same cycle cancel out.
          if (shot_ev && !hit_ev) begin
            ammo_nx = bcd_dec(ammo);
            if (ammo == 8'h01) state_nx = ST_EMPTY;
          end else if (hit_ev && !shot_ev) begin
            ammo_nx = bcd_inc_sat(ammo);
          end
`else
          if (shot_ev) begin
            ammo_nx = bcd_dec(ammo);
            if (ammo == 8'h01) state_nx = ST_EMPTY;
          end
`endif
        end
      end
      ST_EMPTY: begin
        if (reload_trig) begin
          state_nx = ST_RELOAD;
          cnt_nx   = '0;
        end else if (shot_ev) begin
          dry_nx = 1'b1;
        end
      end
      ST_RELOAD: begin
        // Reload requests are ignored here; the timer never restarts.
        if (shot_ev) dry_nx = 1'b1;
        if (cnt == CNT_LAST) begin
          state_nx = ST_READY;
          ammo_nx  = AMMO_FULL;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nx = ST_READY;
        ammo_nx  = AMMO_FULL;
        cnt_nx   = '0;
      end
    endcase
  end

  // Stage p1: state, magazine, reload timer and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_READY;
      ammo         <= AMMO_FULL;
      cnt          <= '0;
      shot_allowed <= 1'b1;
      ammo_empty   <= 1'b0;
      reload_busy  <= 1'b0;
      dry_fire     <= 1'b0;
    end else begin
      state        <= state_nx;
      ammo         <= ammo_nx;
      cnt          <= cnt_nx;
      shot_allowed <= (state_nx == ST_READY);
      ammo_empty   <= (state_nx == ST_EMPTY);
      reload_busy  <= (state_nx == ST_RELOAD);
      dry_fire     <= dry_nx;
    end
  end

  assign hex1 = ammo[7:4];
  assign hex0 = ammo[3:0];

endmodule

// File: tb/tb_ctl_ammo.sv
// Bench for ctl_ammo: two instances (AMMO_MAX 34 and 3, reload of 8 clks)
// share one stimulus stream and are compared against a behavioural model.
module tb_ctl_ammo;

  localparam int RC = 8;
  localparam int M_READY  = 0;
  localparam int M_EMPTY  = 1;
  localparam int M_RELOAD = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic shot_fired = 1'b0, hit = 1'b0, new_round = 1'b0, reload_req = 1'b0;

  logic [3:0] hex0_a, hex1_a, hex0_b, hex1_b;
  logic shot_allowed_a, ammo_empty_a, reload_busy_a, dry_fire_a;
  logic shot_allowed_b, ammo_empty_b, reload_busy_b, dry_fire_b;

  always #5 clk = ~clk;

  ctl_ammo #(.AMMO_MAX(34), .RELOAD_CYCLES(RC)) dut_a (
    .clk(clk), .rst(rst), .shot_fired(shot_fired), .hit(hit),
    .new_round(new_round), .reload_req(reload_req),
    .hex0(hex0_a), .hex1(hex1_a), .shot_allowed(shot_allowed_a),
    .ammo_empty(ammo_empty_a), .reload_busy(reload_busy_a), .dry_fire(dry_fire_a)
  );

  ctl_ammo #(.AMMO_MAX(3), .RELOAD_CYCLES(RC)) dut_b (
    .clk(clk), .rst(rst), .shot_fired(shot_fired), .hit(hit),
    .new_round(new_round), .reload_req(reload_req),
    .hex0(hex0_b), .hex1(hex1_b), .shot_allowed(shot_allowed_b),
    .ammo_empty(ammo_empty_b), .reload_busy(reload_busy_b), .dry_fire(dry_fire_b)
  );

  logic [11:0] act_a, act_b, exp_a, exp_b;
  assign act_a = {hex1_a, hex0_a, shot_allowed_a, ammo_empty_a, reload_busy_a, dry_fire_a};
  assign act_b = {hex1_b, hex0_b, shot_allowed_b, ammo_empty_b, reload_busy_b, dry_fire_b};

  int total = 0;
  int bad   = 0;

  // Behavioural model: integer magazine, mode, and remaining reload clocks.
  int m_max [2] = '{34, 3};
  int m_ammo[2];
  int m_mode[2];
  int m_left[2];
  bit m_dry [2];
  bit p_shot, p_hit, p_rr;

  function automatic logic [11:0] expected(input int i);
    return {4'(m_ammo[i] / 10), 4'(m_ammo[i] % 10),
            m_mode[i] == M_READY, m_mode[i] == M_EMPTY, m_mode[i] == M_RELOAD, m_dry[i]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_ammo[i] = m_max[i];
      m_mode[i] = M_READY;
      m_left[i] = 0;
      m_dry[i]  = 1'b0;
    end
    p_shot = 1'b0; p_hit = 1'b0; p_rr = 1'b0;
    exp_a = expected(0);
    exp_b = expected(1);
  endtask

  task automatic model_edge();
    bit se, he, re, trig;
    int net;
    se = shot_fired && !p_shot;
    he = hit && !p_hit;
    re = reload_req && !p_rr;
`ifndef CTL_AMMO_REFUND_EN
    he = 1'b0;
`endif
    trig = new_round || re;
    for (int i = 0; i < 2; i++) begin
      m_dry[i] = 1'b0;
      if (m_mode[i] == M_READY) begin
        if (trig) begin
          m_mode[i] = M_RELOAD; m_left[i] = RC;
        end else begin
          net = int'(he) - int'(se);
          if (net < 0) begin
            m_ammo[i] = m_ammo[i] - 1;
            if (m_ammo[i] == 0) m_mode[i] = M_EMPTY;
          end else if (net > 0 && m_ammo[i] < m_max[i]) begin
            m_ammo[i] = m_ammo[i] + 1;
          end
        end
      end else if (m_mode[i] == M_EMPTY) begin
        if (trig) begin
          m_mode[i] = M_RELOAD; m_left[i] = RC;
        end else if (se) begin
          m_dry[i] = 1'b1;
        end
      end else begin
        if (se) m_dry[i] = 1'b1;
        m_left[i] = m_left[i] - 1;
        if (m_left[i] == 0) begin
          m_mode[i] = M_READY; m_ammo[i] = m_max[i];
        end
      end
    end
    p_shot = shot_fired; p_hit = hit; p_rr = reload_req;
  endtask

  // One clock: drive inputs, advance model at the edge, sample 1 ns later.
  task automatic step(input bit s, input bit h, input bit nr, input bit rr);
    shot_fired = s; hit = h; new_round = nr; reload_req = rr;
    @(posedge clk);
    model_edge();
    #1;
    exp_a = expected(0);
    exp_b = expected(1);
  endtask

  task automatic do_reset();
    shot_fired = 1'b0; hit = 1'b0; new_round = 1'b0; reload_req = 1'b0;
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (act_a !== 12'h348) begin
      bad++; $display("FAIL reset_a got=%h want=%h", act_a, 12'h348);
    end
    total++;
    if (act_b !== 12'h038) begin
      bad++; $display("FAIL reset_b got=%h want=%h", act_b, 12'h038);
    end
  endtask

  task automatic test_shots();
    for (int k = 0; k < 10; k++) begin
      step(k % 2 == 0, 1'b0, 1'b0, 1'b0);
      total++;
      if (act_a !== exp_a) begin
        bad++; $display("FAIL shots_a k=%0d got=%h want=%h", k, act_a, exp_a);
      end
      total++;
      if (act_b !== exp_b) begin
        bad++; $display("FAIL shots_b k=%0d got=%h want=%h", k, act_b, exp_b);
      end
    end
    total++;
    if (act_a[11:4] !== 8'h29) begin
      bad++; $display("FAIL five_shots got=%h want=29", act_a[11:4]);
    end
    for (int k = 0; k < 21; k++) begin
      step(k < 20, 1'b0, 1'b0, 1'b0);
      total++;
      if (act_a !== exp_a) begin
        bad++; $display("FAIL held_a k=%0d got=%h want=%h", k, act_a, exp_a);
      end
    end
    total++;
    if (act_a[11:4] !== 8'h28) begin
      bad++; $display("FAIL held_once got=%h want=28", act_a[11:4]);
    end
  endtask

  task automatic test_empty();
    do_reset();
    for (int k = 0; k < 6; k++) begin
      step(k % 2 == 0, 1'b0, 1'b0, 1'b0);
      total++;
      if (act_b !== exp_b) begin
        bad++; $display("FAIL empty_b k=%0d got=%h want=%h", k, act_b, exp_b);
      end
    end
    total++;
    if (act_b !== 12'h004) begin
      bad++; $display("FAIL empty_flag got=%h want=004", act_b);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    total++;
    if (act_b !== 12'h005) begin
      bad++; $display("FAIL dry_pulse got=%h want=005", act_b);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (act_b !== 12'h004) begin
      bad++; $display("FAIL dry_clear got=%h want=004", act_b);
    end
  endtask

  task automatic test_reload();
    int busy_cnt;
    int dry_cnt;
    bit done;
    busy_cnt = 0; dry_cnt = 0; done = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    if (reload_busy_b) busy_cnt++;
    for (int k = 0; k < 20 && !done; k++) begin
      step(k % 2 == 0, 1'b0, 1'b0, k == 3);
      total++;
      if (act_b !== exp_b) begin
        bad++; $display("FAIL reload_b k=%0d got=%h want=%h", k, act_b, exp_b);
      end
      total++;
      if (act_a !== exp_a) begin
        bad++; $display("FAIL reload_a k=%0d got=%h want=%h", k, act_a, exp_a);
      end
      if (dry_fire_b) dry_cnt++;
      if (reload_busy_b) busy_cnt++;
      else done = 1'b1;
    end
    total++;
    if (busy_cnt !== RC) begin
      bad++; $display("FAIL reload_len got=%0d want=%0d", busy_cnt, RC);
    end
    total++;
    if (dry_cnt == 0) begin
      bad++; $display("FAIL reload_dry got=%0d want=nonzero", dry_cnt);
    end
    total++;
    if ({hex1_b, hex0_b, shot_allowed_b} !== 9'b0000_0011_1) begin
      bad++; $display("FAIL reload_full got=%h%h/%b want=03/1", hex1_b, hex0_b, shot_allowed_b);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_round_shot();
    do_reset();
    for (int k = 0; k < 48; k++) step(k % 2 == 0, 1'b0, 1'b0, 1'b0);
    total++;
    if (act_a !== 12'h108) begin
      bad++; $display("FAIL at_ten got=%h want=108", act_a);
    end
    step(1'b1, 1'b0, 1'b1, 1'b0);
    total++;
    if (act_a !== 12'h102) begin
      bad++; $display("FAIL round_shot got=%h want=102", act_a);
    end
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      total++;
      if (act_a !== exp_a) begin
        bad++; $display("FAIL round_hold k=%0d got=%h want=%h", k, act_a, exp_a);
      end
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (act_a !== 12'h348) begin
      bad++; $display("FAIL mid_reset_a got=%h want=348", act_a);
    end
    total++;
    if (act_b !== 12'h038) begin
      bad++; $display("FAIL mid_reset_b got=%h want=038", act_b);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

`ifdef CTL_AMMO_REFUND_EN
  task automatic test_refund();
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    total++;
    if (act_a[11:4] !== 8'h34) begin
      bad++; $display("FAIL refund_up got=%h want=34", act_a[11:4]);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    total++;
    if (act_a[11:4] !== 8'h34) begin
      bad++; $display("FAIL refund_sat got=%h want=34", act_a[11:4]);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 28; k++) step(k % 2 == 0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    total++;
    if (act_a[11:4] !== 8'h20) begin
      bad++; $display("FAIL refund_net got=%h want=20", act_a[11:4]);
    end
    total++;
    if (act_b !== exp_b) begin
      bad++; $display("FAIL refund_b got=%h want=%h", act_b, exp_b);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 600; k++) begin
      step($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 60) == 0, $urandom_range(0, 25) == 0);
      total++;
      if (act_a !== exp_a) begin
        bad++; $display("FAIL random_a k=%0d got=%h want=%h", k, act_a, exp_a);
      end
      total++;
      if (act_b !== exp_b) begin
        bad++; $display("FAIL random_b k=%0d got=%h want=%h", k, act_b, exp_b);
      end
    end
  endtask

  initial begin
    test_reset();
    test_shots();
    test_empty();
    test_reload();
    test_round_shot();
`ifdef CTL_AMMO_REFUND_EN
    test_refund();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
